// File: rtl/tile_map_scheduler.sv
// Tile map scheduler: 40x30 tile map with per-tile display prefetch and vblank-only host commits.
// Build macro TILE_FRAME_TICK_EN enables the start-of-vblank frame_tick pulse (tied low otherwise).
module tile_map_scheduler #(
    parameter int unsigned MAP_COLS = 40,
    parameter int unsigned MAP_ROWS = 30,
    parameter int unsigned WQ_DEPTH = 16,
    parameter int unsigned HTOTAL   = 1600,
    parameter int unsigned VTOTAL   = 525,
    parameter int unsigned VACTIVE  = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        chipselect,
    input  logic        write,
    input  logic [10:0] address,
    input  logic [7:0]  writedata,
    output logic        waitrequest,
    output logic [3:0]  tile_id,
    output logic [7:0]  sprite_addr,
    output logic        frame_tick
);
    localparam int unsigned MAP_SIZE = MAP_COLS * MAP_ROWS;
    localparam int unsigned AW       = 11;
    localparam int unsigned TW       = 4;
    localparam int unsigned EW       = AW + TW;
    localparam int unsigned PW       = $clog2(WQ_DEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned HACTIVE  = 1280;
    localparam int unsigned PF_LIMIT = 1248;
    localparam int unsigned LS_SLOT  = HTOTAL - 32;

    logic [TW-1:0] map_ram [MAP_SIZE];
    logic [EW-1:0] wq_mem  [WQ_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] rd_data;
    logic [TW-1:0] next_tile;
    logic [TW-1:0] cur_tile;
    logic          pf_pending;

    logic          push_c;
    logic          pop_c;
    logic          pf_active_c;
    logic          pf_line_c;
    logic          pf_slot_c;
    logic          active_c;
    logic          in_range_c;
    logic [9:0]    next_line_c;
    logic [4:0]    pf_row_c;
    logic [5:0]    pf_col_c;
    logic [AW-1:0] pf_addr_c;
    logic [EW-1:0] head_c;
    logic [AW-1:0] head_addr_c;
    logic [TW-1:0] head_data_c;
    logic          unused_bits_c;

    // Slot decode, FIFO handshake and commit arbitration (prefetch always wins)
    always_comb begin
        next_line_c = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        pf_active_c = (vcount < 10'(VACTIVE)) && (hcount[4:0] == 5'd0)
                      && (hcount < 11'(PF_LIMIT));
        pf_line_c   = (hcount == 11'(LS_SLOT));
        pf_slot_c   = pf_active_c || pf_line_c;
        pf_row_c    = vcount[8:4];
        pf_col_c    = hcount[10:5] + 6'd1;
        if (pf_line_c) begin
            pf_row_c = next_line_c[8:4];
            pf_col_c = 6'd0;
        end
        pf_addr_c   = 11'(pf_row_c) * 11'(MAP_COLS) + 11'(pf_col_c);

        waitrequest = (count == CW'(WQ_DEPTH));
        push_c      = chipselect && write && !waitrequest;
        head_c      = wq_mem[rd_ptr];
        head_addr_c = head_c[EW-1:TW];
        head_data_c = head_c[TW-1:0];
        in_range_c  = (head_addr_c < AW'(MAP_SIZE));
        pop_c       = (vcount >= 10'(VACTIVE)) && (count != '0) && !pf_slot_c;
        active_c    = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));
        unused_bits_c = ^{writedata[7:4], next_line_c[9], next_line_c[3:0]};
    end

    // Single-port map RAM; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (pf_slot_c) begin
            if (pf_addr_c < AW'(MAP_SIZE)) begin
                rd_data <= map_ram[pf_addr_c];
            end else begin
                rd_data <= '0;
            end
        end else if (pop_c && in_range_c) begin
            map_ram[head_addr_c] <= head_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            wq_mem[wr_ptr] <= {address, writedata[3:0]};
        end
    end

    // FIFO pointers, tile pipeline and registered pixel outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pf_pending  <= 1'b0;
            next_tile   <= '0;
            cur_tile    <= '0;
            tile_id     <= '0;
            sprite_addr <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CW'(1);
            end
            pf_pending <= pf_slot_c;
            if (pf_pending && (hcount[4:0] == 5'd1)) begin
                next_tile <= rd_data;
            end
            if (hcount[4:0] == 5'd31) begin
                cur_tile <= next_tile;
            end
            if (active_c) begin
                tile_id     <= cur_tile;
                sprite_addr <= {vcount[3:0], hcount[4:1]};
            end else begin
                tile_id     <= '0;
                sprite_addr <= '0;
            end
        end
    end

`ifdef TILE_FRAME_TICK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (hcount == 11'd0) && (vcount == 10'(VACTIVE));
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Self-checking bench for tile_map_scheduler; the bench plays vga_counters and the Avalon host.
module tb_tile_map_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [10:0] address = '0;
    logic [7:0]  writedata = '0;
    logic        waitrequest;
    logic [3:0]  tile_id;
    logic [7:0]  sprite_addr;
    logic        frame_tick;

`ifdef TILE_FRAME_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int col0_ovr = -1;
    logic [3:0]  model_map [1200];
    logic [14:0] pend_q [$];
    logic [11:0] exp_q [$];

    tile_map_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .tile_id     (tile_id),
        .sprite_addr (sprite_addr),
        .frame_tick  (frame_tick)
    );

    always #10 clk = ~clk;

    // One clock with the given counters and optional write; returns whether the write was taken
    task automatic cyc(input int h, input int v, input bit wr, input int a,
                       input logic [7:0] d, output bit acc);
        hcount     = 11'(h);
        vcount     = 10'(v);
        chipselect = wr;
        write      = wr;
        address    = 11'(a);
        writedata  = d;
        acc        = wr && (waitrequest == 1'b0);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        if (acc) pend_q.push_back({11'(a), d[3:0]});
    endtask

    // Commit everything the host has queued, in order; out-of-range entries vanish
    task automatic apply_pending();
        logic [14:0] e;
        while (pend_q.size() > 0) begin
            e = pend_q.pop_front();
            if (int'(e[14:4]) < 1200) model_map[int'(e[14:4])] = e[3:0];
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40; i++) cyc(i, 480, 1'b0, 0, 8'h00, acc);
        apply_pending();
    endtask

    function automatic logic [11:0] exp_pix(input int h, input int v);
        logic [3:0]  t;
        logic [11:0] r;
        r = '0;
        if (h < 1280 && v < 480) begin
            t = model_map[(v / 16) * 40 + h / 32];
            if (h < 32 && col0_ovr >= 0) t = 4'(col0_ovr);
            r = {t, 4'(v % 16), 4'((h % 32) / 2)};
        end
        return r;
    endfunction

    // Display one line, optionally primed from the previous line's line-start slot
    task automatic scan_line(input int v, input bit prime);
        int pv;
        int h;
        int vv;
        bit acc;
        logic [11:0] got;
        logic [11:0] want;
        pv = (v == 0) ? 524 : v - 1;
        for (int i = (prime ? 0 : 32); i < 1632; i++) begin
            if (i < 32) begin h = 1568 + i; vv = pv; end
            else        begin h = i - 32;   vv = v;  end
            exp_q.push_back(exp_pix(h, vv));
            cyc(h, vv, 1'b0, 0, 8'h00, acc);
            got  = {tile_id, sprite_addr};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disp v=%0d h=%0d got tile=%0d spr=%02h want tile=%0d spr=%02h",
                         vv, h, got[11:8], got[7:0], want[11:8], want[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        bit acc;
        for (int i = 0; i < 3; i++) cyc(100 + i, 50, 1'b0, 0, 8'h00, acc);
        checks++;
        if ({waitrequest, tile_id, sprite_addr, frame_tick} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values got wr=%b tile=%0d spr=%02h tick=%b want all 0",
                     waitrequest, tile_id, sprite_addr, frame_tick);
        end
        reset_n = 1'b1;
    endtask

    task automatic init_map();
        bit acc;
        for (int a = 0; a < 1200; a++) begin
            cyc(a, 480, 1'b1, a, 8'h00, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL init_accept addr=%0d got rejected want accepted", a);
            end
        end
        for (int i = 0; i < 20; i++) cyc(1200 + i, 480, 1'b0, 0, 8'h00, acc);
        apply_pending();
    endtask

    task automatic test_commit_display();
        bit acc;
        cyc(100, 10, 1'b1, 41, 8'hF3, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL commit_accept got rejected want accepted");
        end
        scan_line(16, 1'b1);
        drain();
        scan_line(16, 1'b1);
        scan_line(20, 1'b1);
        scan_line(31, 1'b1);
        scan_line(32, 1'b1);
    endtask

    task automatic test_backpressure();
        bit acc;
        int a;
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            a = (i < 16) ? 80 + i : 80;
            d = (i < 16) ? 8'((i % 15) + 1) : 8'h0E;
            cyc(i, 100, 1'b1, a, d, acc);
            checks++;
            if (acc !== (i < 16)) begin
                errors++;
                $display("FAIL bp_accept i=%0d got %b want %b", i, acc, (i < 16));
            end
            checks++;
            if (waitrequest !== (i >= 15)) begin
                errors++;
                $display("FAIL bp_waitrequest i=%0d got %b want %b", i, waitrequest, (i >= 15));
            end
        end
        cyc(0, 480, 1'b1, 80, 8'h0E, acc);
        checks++;
        if (acc || waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_commit got acc=%b wr=%b want acc=0 wr=0", acc, waitrequest);
        end
        cyc(1, 480, 1'b1, 80, 8'h0E, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL bp_retry got rejected want accepted");
        end
        drain();
        scan_line(40, 1'b1);
    endtask

    task automatic test_conflict();
        bit acc;
        logic [3:0] old0;
        for (int i = 0; i < 16; i++) begin
            cyc(20 + i, 100, 1'b1, i, (i == 0) ? 8'h07 : (i == 1) ? 8'h09 : 8'h04, acc);
        end
        checks++;
        if (waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL conflict_full got wr=%b want 1", waitrequest);
        end
        cyc(1568, 524, 1'b0, 0, 8'h00, acc);
        checks++;
        if (waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL conflict_hold got wr=%b want 1", waitrequest);
        end
        cyc(1569, 524, 1'b0, 0, 8'h00, acc);
        checks++;
        if (waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pop got wr=%b want 0", waitrequest);
        end
        for (int h = 1570; h < 1600; h++) cyc(h, 524, 1'b0, 0, 8'h00, acc);
        old0 = model_map[0];
        apply_pending();
        col0_ovr = int'(old0);
        scan_line(0, 1'b0);
        col0_ovr = -1;
        scan_line(0, 1'b1);
    endtask

    task automatic test_out_of_range();
        bit acc;
        cyc(0, 100, 1'b1, 1200, 8'h05, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL oor_accept_1200 got rejected want accepted");
        end
        cyc(1, 100, 1'b1, 2047, 8'h0A, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL oor_accept_2047 got rejected want accepted");
        end
        drain();
        scan_line(0, 1'b1);
        scan_line(64, 1'b1);
        scan_line(400, 1'b1);
    endtask

    task automatic test_reset_flush();
        bit acc;
        logic [11:0] want;
        for (int i = 0; i < 16; i++) begin
            cyc(i, 100, 1'b1, 5, 8'h09, acc);
            checks++;
            if (waitrequest !== (i == 15)) begin
                errors++;
                $display("FAIL flush_fill i=%0d got wr=%b want %b", i, waitrequest, (i == 15));
            end
        end
        for (int h = 1568; h < 1600; h++) cyc(h, 39, 1'b0, 0, 8'h00, acc);
        for (int h = 0; h < 6; h++) cyc(h, 40, 1'b0, 0, 8'h00, acc);
        want = exp_pix(5, 40);
        checks++;
        if (tile_id !== want[11:8]) begin
            errors++;
            $display("FAIL flush_pre_tile got %0d want %0d", tile_id, want[11:8]);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({waitrequest, tile_id, sprite_addr} !== 13'd0) begin
            errors++;
            $display("FAIL flush_async got wr=%b tile=%0d spr=%02h want all 0",
                     waitrequest, tile_id, sprite_addr);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        pend_q.delete();
        drain();
        scan_line(0, 1'b1);
    endtask

    task automatic test_tick();
        bit acc;
        int pulses;
        bit want;
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            if (i < 10) cyc(1590 + i, 479, 1'b0, 0, 8'h00, acc);
            else        cyc(i - 10, 480, 1'b0, 0, 8'h00, acc);
            want = TICK_EN && (i == 10);
            if (frame_tick) pulses++;
            checks++;
            if (frame_tick !== want) begin
                errors++;
                $display("FAIL tick_cycle i=%0d got %b want %b", i, frame_tick, want);
            end
        end
        checks++;
        if (pulses != (TICK_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL tick_count got %0d want %0d", pulses, TICK_EN ? 1 : 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1200; i++) model_map[i] = 4'd0;
        test_reset();
        init_map();
        test_commit_display();
        test_backpressure();
        test_conflict();
        test_out_of_range();
        test_reset_flush();
        test_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
